// File: rtl/branch_resolve_unit.sv
// Branch/SLT resolve unit: operand compare, funct3 decode, mispredict/illegal flags,
// optional compare/decision pipeline registers and saturating taken/mispredict counters.
module branch_resolve_unit #(
    parameter int XLEN        = 32,
    parameter int PIPE_STAGE0 = 0,
    parameter int PIPE_STAGE1 = 0,
    parameter int TAG_W       = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_valid,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_slt_op,
    input  logic             i_br_signed,
    input  logic             i_is_branch,
    input  logic [2:0]       i_funct3,
    input  logic             i_pred_taken,
    input  logic [XLEN-1:0]  i_rd1,
    input  logic [XLEN-1:0]  i_rd2,
    input  logic             i_flush,
    input  logic             i_cnt_clr,
    output logic             o_valid,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_slt,
    output logic             o_is_branch_valid,
    output logic             o_mispredict,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_taken_cnt,
    output logic [CNT_W-1:0] o_mispred_cnt
);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             slt_op;
        logic             is_branch;
        logic [2:0]       funct3;
        logic             pred_taken;
        logic             lt;
        logic             eq;
    } cmp_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             slt;
        logic             taken;
        logic             mispredict;
        logic             illegal;
    } dec_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // vld_pipe[0]: request entering, [1]: after compare, [2]: after decision
    logic [2:0]         vld_pipe;
    cmp_t               cmp_d, cmp_q;
    dec_t               dec_d, dec_q;
    logic signed [XLEN:0] op1_x, op2_x;
    logic               br_cond;
    logic               illegal;

    // Compare stage: one extra bit turns signed and unsigned into a single signed compare
    always_comb begin
        op1_x            = {i_br_signed & i_rd1[XLEN-1], i_rd1};
        op2_x            = {i_br_signed & i_rd2[XLEN-1], i_rd2};
        cmp_d            = '0;
        cmp_d.tag        = i_tag;
        cmp_d.slt_op     = i_slt_op;
        cmp_d.is_branch  = i_is_branch;
        cmp_d.funct3     = i_funct3;
        cmp_d.pred_taken = i_pred_taken;
        cmp_d.lt         = (op1_x < op2_x);
        cmp_d.eq         = (i_rd1 == i_rd2);
    end

    assign vld_pipe[0] = i_valid & ~i_flush;

    generate
        if (PIPE_STAGE0 != 0) begin : g_s0_reg
            logic vld_q;
            cmp_t cmp_r;
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    vld_q <= 1'b0;
                    cmp_r <= '0;
                end else begin
                    vld_q <= vld_pipe[0] & ~i_flush;
                    cmp_r <= cmp_d;
                end
            end
            assign vld_pipe[1] = vld_q;
            assign cmp_q       = cmp_r;
        end else begin : g_s0_comb
            assign vld_pipe[1] = vld_pipe[0];
            assign cmp_q       = cmp_d;
        end
    endgenerate

    // Decision stage
    always_comb begin
        br_cond = 1'b0;
        case (cmp_q.funct3)
            3'b000:         br_cond = cmp_q.eq;
            3'b001:         br_cond = ~cmp_q.eq;
            3'b100, 3'b110: br_cond = cmp_q.lt;
            3'b101, 3'b111: br_cond = ~cmp_q.lt;
            default:        br_cond = 1'b0;
        endcase
        illegal          = cmp_q.is_branch & (cmp_q.funct3[2:1] == 2'b01);
        dec_d            = '0;
        dec_d.tag        = cmp_q.tag;
        dec_d.taken      = cmp_q.is_branch & br_cond;
        dec_d.illegal    = illegal;
        dec_d.mispredict = cmp_q.is_branch & ~illegal & (dec_d.taken ^ cmp_q.pred_taken);
        dec_d.slt        = cmp_q.slt_op ? cmp_q.lt : 1'b1;
    end

    generate
        if (PIPE_STAGE1 != 0) begin : g_s1_reg
            logic vld_q;
            dec_t dec_r;
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    vld_q <= 1'b0;
                    dec_r <= '0;
                end else begin
                    vld_q <= vld_pipe[1] & ~i_flush;
                    dec_r <= dec_d;
                end
            end
            assign vld_pipe[2] = vld_q;
            assign dec_q       = dec_r;
        end else begin : g_s1_comb
            assign vld_pipe[2] = vld_pipe[1];
            assign dec_q       = dec_d;
        end
    endgenerate

    // Flush and reset mask the output even when the whole path is combinational
    assign o_valid           = vld_pipe[2] & ~i_flush & reset_n;
    assign o_tag             = dec_q.tag;
    assign o_slt             = dec_q.slt;
    assign o_is_branch_valid = dec_q.taken;
    assign o_mispredict      = dec_q.mispredict;
    assign o_illegal         = dec_q.illegal;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            o_taken_cnt   <= '0;
            o_mispred_cnt <= '0;
        end else if (i_cnt_clr) begin
            o_taken_cnt   <= '0;
            o_mispred_cnt <= '0;
        end else begin
            if (o_valid && dec_q.taken && o_taken_cnt != CNT_MAX)
                o_taken_cnt <= o_taken_cnt + CNT_ONE;
            if (o_valid && dec_q.mispredict && o_mispred_cnt != CNT_MAX)
                o_mispred_cnt <= o_mispred_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench: drives a 0/0 and a 1/1 instance (CNT_W=4) plus a default 0/0 instance
// from shared inputs and checks each against hand-computed results.
module tb_branch_resolve_unit;

    logic        clk;
    logic        reset_n;
    logic        i_valid;
    logic [3:0]  i_tag;
    logic        i_slt_op;
    logic        i_br_signed;
    logic        i_is_branch;
    logic [2:0]  i_funct3;
    logic        i_pred_taken;
    logic [31:0] i_rd1;
    logic [31:0] i_rd2;
    logic        i_flush;
    logic        i_cnt_clr;

    logic        v00, slt00, tk00, mp00, il00;
    logic [3:0]  tag00, tc00, mc00;
    logic        v11, slt11, tk11, mp11, il11;
    logic [3:0]  tag11, tc11, mc11;
    logic        vdf, sltdf, tkdf, mpdf, ildf;
    logic [3:0]  tagdf;
    logic [31:0] tcdf, mcdf;

    typedef struct packed {
        logic       v;
        logic [3:0] tag;
        logic       slt;
        logic       tk;
        logic       mp;
        logic       il;
    } res_t;

    res_t res00, res11;
    assign res00 = {v00, tag00, slt00, tk00, mp00, il00};
    assign res11 = {v11, tag11, slt11, tk11, mp11, il11};

    int   checks = 0;
    int   errors = 0;
    res_t r00, r11, exp_r;
    logic early11;
    logic [3:0] ct00, cm00, ct11, cm11;

    branch_resolve_unit #(.PIPE_STAGE0(0), .PIPE_STAGE1(0), .CNT_W(4)) u_d00 (
        .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .i_tag(i_tag), .i_slt_op(i_slt_op),
        .i_br_signed(i_br_signed), .i_is_branch(i_is_branch), .i_funct3(i_funct3),
        .i_pred_taken(i_pred_taken), .i_rd1(i_rd1), .i_rd2(i_rd2), .i_flush(i_flush),
        .i_cnt_clr(i_cnt_clr), .o_valid(v00), .o_tag(tag00), .o_slt(slt00),
        .o_is_branch_valid(tk00), .o_mispredict(mp00), .o_illegal(il00),
        .o_taken_cnt(tc00), .o_mispred_cnt(mc00));

    branch_resolve_unit #(.PIPE_STAGE0(1), .PIPE_STAGE1(1), .CNT_W(4)) u_d11 (
        .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .i_tag(i_tag), .i_slt_op(i_slt_op),
        .i_br_signed(i_br_signed), .i_is_branch(i_is_branch), .i_funct3(i_funct3),
        .i_pred_taken(i_pred_taken), .i_rd1(i_rd1), .i_rd2(i_rd2), .i_flush(i_flush),
        .i_cnt_clr(i_cnt_clr), .o_valid(v11), .o_tag(tag11), .o_slt(slt11),
        .o_is_branch_valid(tk11), .o_mispredict(mp11), .o_illegal(il11),
        .o_taken_cnt(tc11), .o_mispred_cnt(mc11));

    branch_resolve_unit u_def (
        .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .i_tag(i_tag), .i_slt_op(i_slt_op),
        .i_br_signed(i_br_signed), .i_is_branch(i_is_branch), .i_funct3(i_funct3),
        .i_pred_taken(i_pred_taken), .i_rd1(i_rd1), .i_rd2(i_rd2), .i_flush(i_flush),
        .i_cnt_clr(i_cnt_clr), .o_valid(vdf), .o_tag(tagdf), .o_slt(sltdf),
        .o_is_branch_valid(tkdf), .o_mispredict(mpdf), .o_illegal(ildf),
        .o_taken_cnt(tcdf), .o_mispred_cnt(mcdf));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_valid   = 1'b0;
        i_flush   = 1'b0;
        i_cnt_clr = 1'b0;
    endtask

    task automatic drive(input logic [3:0] tag, input logic slt_op, input logic sgn,
                         input logic br, input logic [2:0] f3, input logic pred,
                         input logic [31:0] a, input logic [31:0] b);
        i_valid      = 1'b1;
        i_tag        = tag;
        i_slt_op     = slt_op;
        i_br_signed  = sgn;
        i_is_branch  = br;
        i_funct3     = f3;
        i_pred_taken = pred;
        i_rd1        = a;
        i_rd2        = b;
    endtask

    task automatic clr_cnt();
        idle();
        i_cnt_clr = 1'b1;
        tick();
        i_cnt_clr = 1'b0;
    endtask

    // One request, then capture both instances' results and counters at their latencies
    task automatic fire(input logic [3:0] tag, input logic slt_op, input logic sgn,
                        input logic br, input logic [2:0] f3, input logic pred,
                        input logic [31:0] a, input logic [31:0] b);
        drive(tag, slt_op, sgn, br, f3, pred, a, b);
        @(negedge clk); r00 = res00;
        tick(); idle();
        @(negedge clk); early11 = v11; ct00 = tc00; cm00 = mc00;
        tick();
        @(negedge clk); r11 = res11;
        tick();
        @(negedge clk); ct11 = tc11; cm11 = mc11;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle();
        drive(4'd2, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 32'h1, 32'h1);
        #1;
        checks++; if (v00 !== 1'b0) begin errors++; $display("FAIL reset_comb_valid00: got %b want 0", v00); end
        tick(); tick();
        @(negedge clk);
        checks++; if (v11 !== 1'b0) begin errors++; $display("FAIL reset_valid11: got %b want 0", v11); end
        checks++; if ({tc00, mc00, tc11, mc11} !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %h want 0000", {tc00, mc00, tc11, mc11}); end
        checks++; if ({tcdf, mcdf} !== 64'h0) begin errors++; $display("FAIL reset_cnt_def: got %h want 0", {tcdf, mcdf}); end
        reset_n = 1'b1;
        idle();
        tick();
        @(negedge clk);
        checks++; if ({v00, v11} !== 2'b00) begin errors++; $display("FAIL post_reset_valid: got %b want 00", {v00, v11}); end
        tick();
    endtask

    task automatic test_blt();
        fire(4'd1, 1'b0, 1'b1, 1'b1, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'h1);
        exp_r = {1'b1, 4'd1, 1'b1, 1'b1, 1'b1, 1'b0};
        checks++; if (r00 !== exp_r) begin errors++; $display("FAIL blt_res00: got %h want %h", r00, exp_r); end
        checks++; if (r11 !== exp_r) begin errors++; $display("FAIL blt_res11: got %h want %h", r11, exp_r); end
        checks++; if (early11 !== 1'b0) begin errors++; $display("FAIL blt_latency11: got %b want 0", early11); end
        checks++; if ({ct00, cm00} !== 8'h11) begin errors++; $display("FAIL blt_cnt00: got %h want 11", {ct00, cm00}); end
        checks++; if ({ct11, cm11} !== 8'h11) begin errors++; $display("FAIL blt_cnt11: got %h want 11", {ct11, cm11}); end
    endtask

    task automatic test_bltu();
        fire(4'd2, 1'b0, 1'b0, 1'b1, 3'b110, 1'b1, 32'hFFFF_FFFF, 32'h1);
        exp_r = {1'b1, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0};
        checks++; if (r00 !== exp_r) begin errors++; $display("FAIL bltu_res00: got %h want %h", r00, exp_r); end
        checks++; if (r11 !== exp_r) begin errors++; $display("FAIL bltu_res11: got %h want %h", r11, exp_r); end
        checks++; if ({ct00, cm00} !== 8'h12) begin errors++; $display("FAIL bltu_cnt00: got %h want 12", {ct00, cm00}); end
        checks++; if ({ct11, cm11} !== 8'h12) begin errors++; $display("FAIL bltu_cnt11: got %h want 12", {ct11, cm11}); end
    endtask

    task automatic test_decode();
        fire(4'd4, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 32'hFFFF_FFFF, 32'h1);
        exp_r = {1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0};
        checks++; if (r00 !== exp_r) begin errors++; $display("FAIL slt_signed00: got %h want %h", r00, exp_r); end
        checks++; if (r11 !== exp_r) begin errors++; $display("FAIL slt_signed11: got %h want %h", r11, exp_r); end
        fire(4'd5, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 32'hFFFF_FFFF, 32'h1);
        exp_r = {1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++; if (r00 !== exp_r) begin errors++; $display("FAIL sltu00: got %h want %h", r00, exp_r); end
        checks++; if (r11 !== exp_r) begin errors++; $display("FAIL sltu11: got %h want %h", r11, exp_r); end
        fire(4'd6, 1'b0, 1'b0, 1'b1, 3'b011, 1'b1, 32'h5, 32'h5);
        exp_r = {1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b1};
        checks++; if (r00 !== exp_r) begin errors++; $display("FAIL illegal00: got %h want %h", r00, exp_r); end
        checks++; if (r11 !== exp_r) begin errors++; $display("FAIL illegal11: got %h want %h", r11, exp_r); end
        checks++; if ({ct00, cm00, ct11, cm11} !== 16'h1212) begin errors++; $display("FAIL illegal_cnt: got %h want 1212", {ct00, cm00, ct11, cm11}); end
        fire(4'd7, 1'b0, 1'b0, 1'b1, 3'b001, 1'b1, 32'h3, 32'h4);
        exp_r = {1'b1, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0};
        checks++; if (r00 !== exp_r) begin errors++; $display("FAIL bne00: got %h want %h", r00, exp_r); end
        checks++; if (r11 !== exp_r) begin errors++; $display("FAIL bne11: got %h want %h", r11, exp_r); end
        fire(4'd8, 1'b0, 1'b0, 1'b1, 3'b111, 1'b0, 32'hFFFF_FFFF, 32'h1);
        exp_r = {1'b1, 4'd8, 1'b1, 1'b1, 1'b1, 1'b0};
        checks++; if (r00 !== exp_r) begin errors++; $display("FAIL bgeu00: got %h want %h", r00, exp_r); end
        checks++; if (r11 !== exp_r) begin errors++; $display("FAIL bgeu11: got %h want %h", r11, exp_r); end
        fire(4'd9, 1'b0, 1'b1, 1'b1, 3'b101, 1'b0, 32'hFFFF_FFFF, 32'h1);
        exp_r = {1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0};
        checks++; if (r00 !== exp_r) begin errors++; $display("FAIL bge00: got %h want %h", r00, exp_r); end
        checks++; if (r11 !== exp_r) begin errors++; $display("FAIL bge11: got %h want %h", r11, exp_r); end
        checks++; if ({ct00, cm00, ct11, cm11} !== 16'h3333) begin errors++; $display("FAIL decode_cnt: got %h want 3333", {ct00, cm00, ct11, cm11}); end
    endtask

    task automatic test_back_to_back();
        clr_cnt();
        drive(4'd3, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 32'h10, 32'h10);
        @(negedge clk);
        checks++; if ({v00, tag00, v11} !== 6'b1_0011_0) begin errors++; $display("FAIL b2b_c0: got %b want 1_0011_0", {v00, tag00, v11}); end
        tick(); i_tag = 4'd5;
        @(negedge clk);
        checks++; if (v11 !== 1'b0) begin errors++; $display("FAIL b2b_c1_valid11: got %b want 0", v11); end
        tick(); i_tag = 4'd7;
        @(negedge clk);
        checks++; if ({v11, tag11} !== 5'b1_0011) begin errors++; $display("FAIL b2b_c2: got %b want 1_0011", {v11, tag11}); end
        tick(); idle();
        @(negedge clk);
        checks++; if ({v11, tag11} !== 5'b1_0101) begin errors++; $display("FAIL b2b_c3: got %b want 1_0101", {v11, tag11}); end
        tick();
        @(negedge clk);
        checks++; if ({v11, tag11} !== 5'b1_0111) begin errors++; $display("FAIL b2b_c4: got %b want 1_0111", {v11, tag11}); end
        tick();
        @(negedge clk);
        checks++; if (v11 !== 1'b0) begin errors++; $display("FAIL b2b_c5_valid11: got %b want 0", v11); end
        checks++; if ({tc00, tc11, mc11} !== 12'h330) begin errors++; $display("FAIL b2b_cnt: got %h want 330", {tc00, tc11, mc11}); end
        tick();
    endtask

    task automatic test_flush();
        clr_cnt();
        drive(4'd1, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 32'h20, 32'h20);
        tick();
        i_tag = 4'd2; i_flush = 1'b1;
        @(negedge clk);
        checks++; if (v00 !== 1'b0) begin errors++; $display("FAIL flush_comb_valid00: got %b want 0", v00); end
        tick();
        i_tag = 4'd3; i_flush = 1'b0;
        @(negedge clk);
        checks++; if (v11 !== 1'b0) begin errors++; $display("FAIL flush_killed_tag1: got %b want 0", v11); end
        tick(); idle();
        @(negedge clk);
        checks++; if (v11 !== 1'b0) begin errors++; $display("FAIL flush_dropped_tag2: got %b want 0", v11); end
        tick();
        @(negedge clk);
        checks++; if ({v11, tag11} !== 5'b1_0011) begin errors++; $display("FAIL flush_tag3: got %b want 1_0011", {v11, tag11}); end
        tick();
        @(negedge clk);
        checks++; if ({tc00, tc11} !== 8'h21) begin errors++; $display("FAIL flush_cnt: got %h want 21", {tc00, tc11}); end
        tick();
        drive(4'd4, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 32'h20, 32'h20);
        tick(); idle();
        tick();
        i_flush = 1'b1;
        @(negedge clk);
        checks++; if (v11 !== 1'b0) begin errors++; $display("FAIL flush_out_stage11: got %b want 0", v11); end
        tick(); i_flush = 1'b0;
        @(negedge clk);
        checks++; if ({v11, tc00, tc11} !== 9'h031) begin errors++; $display("FAIL flush_out_cnt: got %h want 031", {v11, tc00, tc11}); end
        tick();
    endtask

    task automatic test_saturate();
        clr_cnt();
        for (int i = 0; i < 20; i++) begin
            drive(4'(i), 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 32'h7, 32'h7);
            tick();
        end
        idle();
        tick(); tick(); tick();
        @(negedge clk);
        checks++; if ({tc00, tc11} !== 8'hFF) begin errors++; $display("FAIL sat_cnt4: got %h want ff", {tc00, tc11}); end
        checks++; if (tcdf !== 32'd20) begin errors++; $display("FAIL sat_cnt32: got %0d want 20", tcdf); end
        checks++; if ({mc00, mc11} !== 8'h00) begin errors++; $display("FAIL sat_mispred: got %h want 00", {mc00, mc11}); end
        drive(4'd1, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 32'h7, 32'h7);
        i_cnt_clr = 1'b1;
        tick(); idle(); i_cnt_clr = 1'b1;
        @(negedge clk);
        checks++; if ({tc00, tcdf} !== 36'h0) begin errors++; $display("FAIL clr_prio00: got %h want 0", {tc00, tcdf}); end
        tick(); i_cnt_clr = 1'b1;
        @(negedge clk);
        checks++; if ({v11, tk11} !== 2'b11) begin errors++; $display("FAIL clr_prio_out11: got %b want 11", {v11, tk11}); end
        tick(); i_cnt_clr = 1'b0;
        @(negedge clk);
        checks++; if (tc11 !== 4'h0) begin errors++; $display("FAIL clr_prio11: got %h want 0", tc11); end
        tick();
    endtask

    task automatic test_reset_mid();
        drive(4'd9, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 32'h1, 32'h1);
        tick();
        i_tag = 4'd10; reset_n = 1'b0;
        @(negedge clk);
        checks++; if ({v00, tc00} !== 5'b0_0001) begin errors++; $display("FAIL rst_mid_c1: got %b want 0_0001", {v00, tc00}); end
        tick(); reset_n = 1'b1; idle();
        @(negedge clk);
        checks++; if (v11 !== 1'b0) begin errors++; $display("FAIL rst_mid_stale9: got %b want 0", v11); end
        checks++; if ({tc00, mc00, tc11, mc11} !== 16'h0) begin errors++; $display("FAIL rst_mid_cnt: got %h want 0000", {tc00, mc00, tc11, mc11}); end
        checks++; if (tcdf !== 32'h0) begin errors++; $display("FAIL rst_mid_cnt_def: got %h want 0", tcdf); end
        tick();
        @(negedge clk);
        checks++; if (v11 !== 1'b0) begin errors++; $display("FAIL rst_mid_stale10: got %b want 0", v11); end
        tick();
        @(negedge clk);
        checks++; if ({v11, tc11} !== 5'b0) begin errors++; $display("FAIL rst_mid_tail: got %b want 0", {v11, tc11}); end
        tick();
    endtask

    initial begin
        test_reset();
        test_blt();
        test_bltu();
        test_decode();
        test_back_to_back();
        test_flush();
        test_saturate();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
